// File: rtl/usart_fifo.sv
// usart_fifo: USART with a 16x oversampled transmitter and receiver, each
// backed by a FIFO_DEPTH-entry FIFO. The TX FIFO is written with n_WR. The RX
// FIFO is first-word-fall-through and is popped with rd_en. Sticky error flags
// and an active-low interrupt report receive errors.
// Optional feature: define USART_PARITY_EN to send and check a parity bit
// (even parity when PARITY_ODD = 0, odd parity when PARITY_ODD = 1).
module usart_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK50M,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 n_WR,
    output logic                 TxD,
    output logic                 Tx_RDY,
    output logic                 Tx_IDLE,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 Rx_RDY,
    input  logic                 rd_en,
    output logic [2:0]           err,
    input  logic                 err_clr,
    output logic                 n_INT
);

    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [3:0]    TICK_LAST = 4'd15;
    localparam logic [3:0]    TICK_MID  = 4'd7;
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
`ifdef USART_PARITY_EN
    localparam logic          PAR_EN    = 1'b1;
`else
    localparam logic          PAR_EN    = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit that accompanies a character for the configured sense.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        parity_of = (^d) ^ PAR_ODD;
    endfunction

    // Baud tick generator.
    logic [DW-1:0] div_cnt_r;
    logic          tick_s;

    // TX FIFO and shifter state.
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_ptr_r, tx_rd_ptr_r;
    logic [CW-1:0]        tx_count_r;
    logic                 tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
    state_t               tx_state_r;
    logic [3:0]           tx_tick_r;
    logic [2:0]           tx_bit_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic                 txd_r;

    // RX synchroniser, FIFO and FSM state.
    logic                 rxd_meta_r, rxd_sync_r, rxd_prev_r;
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CW-1:0]        rx_count_r;
    logic                 rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
    logic                 rx_stop_end_s;
    state_t               rx_state_r;
    logic [3:0]           rx_tick_r;
    logic [2:0]           rx_bit_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_wait_r;

    // Error reporting.
    logic [2:0]           err_set_s, err_next_s, err_r;
    logic                 n_int_r;

    assign tick_s     = (div_cnt_r == DIV_LAST);
    assign tx_full_s  = (tx_count_r == DEPTH_C);
    assign tx_empty_s = (tx_count_r == {CW{1'b0}});
    assign rx_full_s  = (rx_count_r == DEPTH_C);
    assign rx_empty_s = (rx_count_r == {CW{1'b0}});
    assign tx_push_s  = ~n_WR & ~tx_full_s;
    // A character leaves the FIFO on a tick, either from idle or right at the
    // end of a stop bit, which makes back-to-back frames gap-free.
    assign tx_pop_s   = tick_s & ~tx_empty_s &
                        ((tx_state_r == ST_IDLE) |
                         ((tx_state_r == ST_STOP) & (tx_tick_r == TICK_LAST)));
    assign rx_pop_s   = rd_en & ~rx_empty_s;

    assign TxD      = txd_r;
    assign Tx_RDY   = ~tx_full_s;
    assign Tx_IDLE  = (tx_state_r == ST_IDLE) & tx_empty_s;
    assign Rx_RDY   = ~rx_empty_s;
    assign DATA_OUT = rx_empty_s ? {DATA_BITS{1'b0}} : rx_mem[rx_rd_ptr_r];
    assign err      = err_r;
    assign n_INT    = n_int_r;

    // Free-running 16x oversampling divider shared by TX and RX.
    always_ff @(posedge CLK50M) begin
        if (RST || tick_s) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    // TX FIFO storage write.
    always_ff @(posedge CLK50M) begin
        if (tx_push_s) begin
            tx_mem[tx_wr_ptr_r] <= DATA_IN;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            tx_wr_ptr_r <= {AW{1'b0}};
            tx_rd_ptr_r <= {AW{1'b0}};
            tx_count_r  <= {CW{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + 1'b1;
                2'b01:   tx_count_r <= tx_count_r - 1'b1;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // TX frame sequencer: start, data LSB first, optional parity, stop.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            tx_state_r <= ST_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            txd_r      <= 1'b1;
        end else if (tx_pop_s) begin
            tx_state_r <= ST_START;
            tx_tick_r  <= 4'd0;
            tx_shift_r <= tx_mem[tx_rd_ptr_r];
            tx_par_r   <= parity_of(tx_mem[tx_rd_ptr_r]);
            txd_r      <= 1'b0;
        end else if (tick_s && tx_state_r != ST_IDLE) begin
            tx_tick_r <= tx_tick_r + 1'b1;
            if (tx_tick_r == TICK_LAST) begin
                case (tx_state_r)
                    ST_START: begin
                        tx_state_r <= ST_DATA;
                        tx_bit_r   <= 3'd0;
                        txd_r      <= tx_shift_r[0];
                        tx_shift_r <= tx_shift_r >> 1;
                    end
                    ST_DATA: begin
                        if (tx_bit_r == LAST_BIT) begin
                            tx_state_r <= PAR_EN ? ST_PARITY : ST_STOP;
                            txd_r      <= PAR_EN ? tx_par_r : 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 1'b1;
                            txd_r      <= tx_shift_r[0];
                            tx_shift_r <= tx_shift_r >> 1;
                        end
                    end
                    ST_PARITY: begin
                        tx_state_r <= ST_STOP;
                        txd_r      <= 1'b1;
                    end
                    default: begin
                        tx_state_r <= ST_IDLE;
                        txd_r      <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Two-flop synchroniser for RxD plus a delayed copy for edge detection.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= RxD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // RX end-of-frame decisions and error events for this cycle.
    always_comb begin
        rx_stop_end_s = tick_s && (rx_state_r == ST_STOP) && !rx_wait_r &&
                        (rx_tick_r == TICK_LAST);
        rx_push_s     = 1'b0;
        err_set_s     = 3'b000;
        if (rx_stop_end_s && rxd_sync_r) begin
            if (!rx_full_s || rx_pop_s) begin
                rx_push_s = 1'b1;
            end else begin
                err_set_s[2] = 1'b1;
            end
        end else if (rx_stop_end_s) begin
            err_set_s[1] = 1'b1;
        end else begin
            rx_push_s = 1'b0;
        end
        if (PAR_EN && tick_s && (rx_state_r == ST_PARITY) &&
            (rx_tick_r == TICK_LAST) && (rxd_sync_r != parity_of(rx_shift_r))) begin
            err_set_s[0] = 1'b1;
        end else begin
            err_set_s[0] = 1'b0;
        end
    end

    // RX frame sampler; samples at mid-bit, waits out a broken stop bit.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rx_state_r <= ST_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= {DATA_BITS{1'b0}};
            rx_wait_r  <= 1'b0;
        end else begin
            case (rx_state_r)
                ST_IDLE: begin
                    rx_tick_r <= 4'd0;
                    if (rxd_prev_r && !rxd_sync_r) rx_state_r <= ST_START;
                end
                ST_START: begin
                    if (tick_s) begin
                        rx_tick_r <= rx_tick_r + 1'b1;
                        if (rx_tick_r == TICK_MID) begin
                            rx_tick_r  <= 4'd0;
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= rxd_sync_r ? ST_IDLE : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        rx_tick_r <= rx_tick_r + 1'b1;
                        if (rx_tick_r == TICK_LAST) begin
                            rx_shift_r <= {rxd_sync_r, rx_shift_r[DATA_BITS-1:1]};
                            if (rx_bit_r == LAST_BIT) begin
                                rx_state_r <= PAR_EN ? ST_PARITY : ST_STOP;
                            end else begin
                                rx_bit_r <= rx_bit_r + 1'b1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        rx_tick_r <= rx_tick_r + 1'b1;
                        if (rx_tick_r == TICK_LAST) rx_state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (rx_wait_r) begin
                        if (rxd_sync_r) begin
                            rx_wait_r  <= 1'b0;
                            rx_state_r <= ST_IDLE;
                        end
                    end else if (tick_s) begin
                        rx_tick_r <= rx_tick_r + 1'b1;
                        if (rx_tick_r == TICK_LAST) begin
                            if (rxd_sync_r) rx_state_r <= ST_IDLE;
                            else            rx_wait_r  <= 1'b1;
                        end
                    end
                end
                default: rx_state_r <= ST_IDLE;
            endcase
        end
    end

    // RX FIFO storage write.
    always_ff @(posedge CLK50M) begin
        if (rx_push_s) begin
            rx_mem[rx_wr_ptr_r] <= rx_shift_r;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rx_wr_ptr_r <= {AW{1'b0}};
            rx_rd_ptr_r <= {AW{1'b0}};
            rx_count_r  <= {CW{1'b0}};
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + 1'b1;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + 1'b1;
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + 1'b1;
                2'b01:   rx_count_r <= rx_count_r - 1'b1;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sticky error update; a new event wins over a simultaneous clear.
    always_comb begin
        if (err_clr) begin
            err_next_s = err_set_s;
        end else begin
            err_next_s = err_r | err_set_s;
        end
    end

    // Registered error flags and interrupt.
    always_ff @(posedge CLK50M) begin
        if (RST) begin
            err_r   <= 3'b000;
            n_int_r <= 1'b1;
        end else begin
            err_r   <= err_next_s;
            n_int_r <= ~|err_next_s;
        end
    end

endmodule

// File: tb/tb_usart_fifo.sv
// Randomised scoreboard bench for usart_fifo. Stimulus pushes expected
// characters into queues. A TX line monitor and an RX FIFO monitor pop them
// independently and compare.
module tb_usart_fifo;
    localparam int CLK_HZ    = 1600000;
    localparam int BAUD      = 25000;
    localparam int DB        = 8;
    localparam int DEPTH     = 4;
    localparam int PODD      = 0;
    localparam int DIV       = 4;
    localparam int BIT_CYC   = 16 * DIV;
`ifdef USART_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif
    localparam int FB        = 1 + DB + PE + 1;
    localparam int FRAME_CYC = FB * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst, n_wr, rd_en, err_clr, rxd_drv, loop_en;
    logic [7:0] data_in, data_out;
    logic       txd, tx_rdy, tx_idle, rx_rdy, n_int, rxd_line;
    logic [2:0] err;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    bit tx_mon_en = 1'b0;
    bit rx_mon_en = 1'b0;

    always #5 clk = ~clk;
    assign rxd_line = loop_en ? txd : rxd_drv;

    usart_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
        .CLK50M(clk), .RST(rst), .DATA_IN(data_in), .n_WR(n_wr),
        .TxD(txd), .Tx_RDY(tx_rdy), .Tx_IDLE(tx_idle), .RxD(rxd_line),
        .DATA_OUT(data_out), .Rx_RDY(rx_rdy), .rd_en(rd_en), .err(err),
        .err_clr(err_clr), .n_INT(n_int));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h", name, act);
    endtask

    // Parity from the character's number of ones.
    function automatic logic par_bit(input logic [7:0] d);
        return ((($countones(d) + PODD) % 2) == 1);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; the push is sampled at the next posedge.
    task automatic push(input logic [7:0] d);
        data_in = d;
        n_wr = 1'b0;
        @(negedge clk);
        n_wr = 1'b1;
    endtask

    task automatic push_hs(input logic [7:0] d, input bit to_rx);
        int w = 0;
        while (!tx_rdy && w < 2 * FRAME_CYC) begin
            @(negedge clk);
            w++;
        end
        if (!tx_rdy) fail("tx_rdy_timeout", w);
        else begin
            tx_exp_q.push_back(d);
            if (to_rx) rx_exp_q.push_back(d);
            push(d);
        end
    endtask

    task automatic wait_tx_idle();
        int w = 0;
        while (!tx_idle && w < (DEPTH + 2) * FRAME_CYC) begin
            @(negedge clk);
            w++;
        end
        chk("tx_idle_reached", tx_idle, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit bad_stop, input bit bad_par);
        rxd_drv = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < DB; i++) begin
            rxd_drv = d[i];
            cycles(BIT_CYC);
        end
        if (PE == 1) begin
            rxd_drv = par_bit(d) ^ bad_par;
            cycles(BIT_CYC);
        end
        rxd_drv = ~bad_stop;
        cycles(BIT_CYC);
        rxd_drv = 1'b1;
        cycles(BIT_CYC);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_after_clr", err, 3'b000);
        chk("n_int_after_clr", n_int, 1);
    endtask

    // TX line monitor: checks each frame bit early and late in its bit time.
    initial begin
        forever begin
            logic [7:0]  d;
            logic [11:0] exp_bits;
            bit          en;
            @(negedge txd);
            en = tx_mon_en;
            d = 8'h00;
            if (en) begin
                if (tx_exp_q.size() == 0) begin
                    fail("tx_unexpected_frame", 32'(txd));
                    en = 1'b0;
                end else begin
                    d = tx_exp_q.pop_front();
                end
            end
            exp_bits = '1;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < DB; i++) exp_bits[1 + i] = d[i];
            if (PE == 1) exp_bits[1 + DB] = par_bit(d);
            exp_bits[FB - 1] = 1'b1;
            for (int c = 0; c < FRAME_CYC - BIT_CYC / 8; c++) begin
                @(posedge clk);
                #1;
                if (en && ((c % BIT_CYC) == BIT_CYC / 8 || (c % BIT_CYC) == 7 * BIT_CYC / 8))
                    chk($sformatf("tx_bit%0d_of_%0h", c / BIT_CYC, d), txd, exp_bits[c / BIT_CYC]);
            end
        end
    end

    // RX FIFO monitor: pops and compares the head whenever one is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_mon_en && rx_rdy) begin
                if (rx_exp_q.size() == 0) fail("rx_unexpected_char", data_out);
                else chk("rx_data", data_out, rx_exp_q.pop_front());
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int z;
        rst = 1'b1; n_wr = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        rxd_drv = 1'b1; loop_en = 1'b0; data_in = 8'h00;
        cycles(3);
        rst = 1'b0;
        chk("rst_txd", txd, 1);
        chk("rst_tx_rdy", tx_rdy, 1);
        chk("rst_tx_idle", tx_idle, 1);
        chk("rst_rx_rdy", rx_rdy, 0);
        chk("rst_n_int", n_int, 1);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_err", err, 3'b000);

        // Single character on the line.
        tx_mon_en = 1'b1;
        push_hs(8'hA5, 1'b0);
        wait_tx_idle();
        cycles(BIT_CYC / 4);
        chk("a5_frames_left", tx_exp_q.size(), 0);

        // Directed loopback.
        loop_en = 1'b1;
        rx_mon_en = 1'b1;
        push_hs(8'h00, 1'b1);
        push_hs(8'hFF, 1'b1);
        push_hs(8'h3C, 1'b1);
        wait_tx_idle();
        cycles(2 * BIT_CYC);
        chk("loop_rx_left", rx_exp_q.size(), 0);
        chk("loop_err", err, 3'b000);

        // Random loopback traffic.
        for (int i = 0; i < 16; i++) begin
            push_hs(8'($urandom), 1'b1);
            cycles($urandom_range(0, 2 * BIT_CYC));
        end
        wait_tx_idle();
        cycles(2 * BIT_CYC);
        chk("rand_tx_left", tx_exp_q.size(), 0);
        chk("rand_rx_left", rx_exp_q.size(), 0);
        chk("rand_err", err, 3'b000);

        // Short low glitch is rejected, then a real frame still arrives.
        loop_en = 1'b0;
        rxd_drv = 1'b0;
        cycles(4 * DIV);
        rxd_drv = 1'b1;
        cycles(2 * BIT_CYC);
        chk("glitch_rx_rdy", rx_rdy, 0);
        chk("glitch_err", err, 3'b000);
        rx_exp_q.push_back(8'hC3);
        send_rx(8'hC3, 1'b0, 1'b0);
        chk("glitch_recover_left", rx_exp_q.size(), 0);

        // Broken stop bit.
        send_rx(8'h55, 1'b1, 1'b0);
        cycles(4);
        chk("frm_err", err, 3'b010);
        chk("frm_n_int", n_int, 0);
        chk("frm_rx_rdy", rx_rdy, 0);
        clear_err();
        rx_exp_q.push_back(8'h81);
        send_rx(8'h81, 1'b0, 1'b0);
        chk("frm_recover_left", rx_exp_q.size(), 0);

        // Parity handling.
        rx_exp_q.push_back(8'h96);
        send_rx(8'h96, 1'b0, 1'b1);
        chk("par_rx_left", rx_exp_q.size(), 0);
        chk("par_err", err, (PE == 1) ? 3'b001 : 3'b000);
        clear_err();

        // RX overrun: one more character than the FIFO holds, no reads.
        rx_mon_en = 1'b0;
        loop_en = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) push_hs(8'(8'h10 + i), (i < DEPTH));
        wait_tx_idle();
        cycles(2 * BIT_CYC);
        chk("ovr_err", err, 3'b100);
        chk("ovr_n_int", n_int, 0);
        chk("ovr_rx_rdy", rx_rdy, 1);
        rx_mon_en = 1'b1;
        cycles(DEPTH + 4);
        chk("ovr_rx_left", rx_exp_q.size(), 0);
        chk("ovr_rx_empty", rx_rdy, 0);
        clear_err();

        // TX FIFO full: one in the shifter, DEPTH queued, the next one ignored.
        loop_en = 1'b0;
        tx_exp_q.push_back(8'h20);
        push(8'h20);
        cycles(3 * DIV);
        for (int i = 0; i < DEPTH; i++) begin
            tx_exp_q.push_back(8'(8'h21 + i));
            push(8'(8'h21 + i));
        end
        chk("txfull_rdy", tx_rdy, 0);
        push(8'hEE);
        wait_tx_idle();
        cycles(BIT_CYC / 4);
        chk("txfull_left", tx_exp_q.size(), 0);

        // Reset in the middle of a frame.
        tx_mon_en = 1'b0;
        push(8'h5A);
        push(8'h33);
        cycles(5 * BIT_CYC);
        chk("pre_rst_busy", tx_idle, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_tx_idle", tx_idle, 1);
        chk("midrst_tx_rdy", tx_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        z = 0;
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            if (!txd) z++;
        end
        chk("midrst_quiet_low_cycles", z, 0);
        tx_mon_en = 1'b1;
        push_hs(8'h77, 1'b0);
        wait_tx_idle();
        cycles(BIT_CYC / 4);
        chk("post_rst_left", tx_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
